// File: rtl/collision_manager.sv
// Collision and game-state manager: arrow/bubble hit strobe with frame cooldown,
// per-frame player/bubble contact detection, lives, invulnerability and game over.
module collision_manager #(
   parameter int START_LIVES       = 3,
   parameter int COOLDOWN_FRAMES   = 4,
   parameter int PLAYER_MIN_PIXELS = 16,
   parameter int INVULN_FRAMES     = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startOfFrame,
   input  logic       start,
   input  logic       bubbleDrawingRequest,
   input  logic       arrowDrawingRequest,
   input  logic       playerDrawingRequest,
   output logic       arrowHit,
   output logic       arrowRetract,
   output logic       playerHit,
   output logic [3:0] lives,
   output logic       invulnerable,
   output logic       gameOver
);

   typedef enum logic [1:0] {
      ST_ARMED     = 2'd0,
      ST_COOLDOWN  = 2'd1,
      ST_GAME_OVER = 2'd2
   } state_e;

   localparam logic [3:0] START_LIVES_C = 4'(START_LIVES);
   localparam logic [3:0] COOLDOWN_C    = 4'(COOLDOWN_FRAMES);
   localparam logic [7:0] PMIN_C        = 8'(PLAYER_MIN_PIXELS);
   localparam logic [7:0] INVULN_C      = 8'(INVULN_FRAMES);

   state_e     state_q, state_d;
   logic [3:0] cool_q, cool_d;
   logic [7:0] overlap_q, overlap_d;
   logic [7:0] invuln_q, invuln_d;
   logic [3:0] lives_q, lives_d;
   logic       game_over_q, game_over_d;
   logic       retract_q, retract_d;
   logic       player_hit_q, player_hit_d;
   logic       invulnerable_q, invulnerable_d;
   logic       arrow_hit_s;
   logic       overlap_px_s;
   logic       player_qual_s;

   // State and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_ARMED;
         cool_q         <= 4'd0;
         overlap_q      <= 8'd0;
         invuln_q       <= 8'd0;
         lives_q        <= START_LIVES_C;
         game_over_q    <= 1'b0;
         retract_q      <= 1'b0;
         player_hit_q   <= 1'b0;
         invulnerable_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cool_q         <= cool_d;
         overlap_q      <= overlap_d;
         invuln_q       <= invuln_d;
         lives_q        <= lives_d;
         game_over_q    <= game_over_d;
         retract_q      <= retract_d;
         player_hit_q   <= player_hit_d;
         invulnerable_q <= invulnerable_d;
      end
   end

   // Player contact, lives and invulnerability next-state
   always_comb begin
      overlap_px_s   = playerDrawingRequest & bubbleDrawingRequest;
      player_qual_s  = startOfFrame && (overlap_q >= PMIN_C) && (invuln_q == 8'd0) && !game_over_q;
      overlap_d      = overlap_q;
      invuln_d       = invuln_q;
      lives_d        = lives_q;
      game_over_d    = game_over_q;
      player_hit_d   = 1'b0;
      if (start) begin
         overlap_d   = 8'd0;
         invuln_d    = 8'd0;
         lives_d     = START_LIVES_C;
         game_over_d = 1'b0;
      end else begin
         // The overlap pixel on the startOfFrame cycle belongs to the new frame.
         if (startOfFrame) begin
            overlap_d = {7'd0, overlap_px_s};
         end else if (overlap_px_s && (overlap_q != 8'hFF)) begin
            overlap_d = overlap_q + 8'd1;
         end else begin
            overlap_d = overlap_q;
         end
         if (player_qual_s) begin
            player_hit_d = 1'b1;
            lives_d      = (lives_q == 4'd0) ? 4'd0 : (lives_q - 4'd1);
            invuln_d     = INVULN_C;
            game_over_d  = game_over_q | (lives_q <= 4'd1);
         end else if (startOfFrame && (invuln_q != 8'd0)) begin
            invuln_d = invuln_q - 8'd1;
         end else begin
            invuln_d = invuln_q;
         end
      end
      invulnerable_d = (invuln_d != 8'd0);
   end

   // Arrow FSM next-state and cooldown counter
   always_comb begin
      state_d   = state_q;
      cool_d    = cool_q;
      retract_d = 1'b0;
      if (start) begin
         state_d = ST_ARMED;
         cool_d  = 4'd0;
      end else if (game_over_d) begin
         state_d = ST_GAME_OVER;
         cool_d  = 4'd0;
      end else begin
         case (state_q)
            ST_ARMED: begin
               if (arrow_hit_s) begin
                  state_d   = ST_COOLDOWN;
                  cool_d    = COOLDOWN_C;
                  retract_d = 1'b1;
               end else begin
                  state_d = ST_ARMED;
               end
            end
            ST_COOLDOWN: begin
               if (startOfFrame && (cool_q <= 4'd1)) begin
                  state_d = ST_ARMED;
                  cool_d  = 4'd0;
               end else if (startOfFrame) begin
                  cool_d = cool_q - 4'd1;
               end else begin
                  cool_d = cool_q;
               end
            end
            ST_GAME_OVER: state_d = ST_GAME_OVER;
            default:      state_d = ST_ARMED;
         endcase
      end
   end

   // Zero-latency hit strobe so the bubble array sees it on its own pixel
   always_comb begin
      case (state_q)
         ST_ARMED: begin
            if (arrowDrawingRequest && bubbleDrawingRequest && !reset) begin
               arrow_hit_s = 1'b1;
            end else begin
               arrow_hit_s = 1'b0;
            end
         end
         default: arrow_hit_s = 1'b0;
      endcase
   end

   assign arrowHit     = arrow_hit_s;
   assign arrowRetract = retract_q;
   assign playerHit    = player_hit_q;
   assign lives        = lives_q;
   assign invulnerable = invulnerable_q;
   assign gameOver     = game_over_q;

endmodule

// File: doc/collision_manager.md
Name: collision_manager

Overview:
- Collision and game-state block that sits between the object drawers and the game-state logic.
- It turns per-pixel bubble/arrow overlap into the single-cycle arrowHit strobe that feeds the bubble array.
- It retracts the arrow after a hit, and detects player/bubble contact over a whole frame.
- It keeps the lives counter, an invulnerability window and the sticky game-over flag.

Parameters:
- START_LIVES, 3: lives loaded on reset and on start.
- COOLDOWN_FRAMES, 4: frames after an arrow hit before arrowHit may fire again. Legal range 1..15.
- PLAYER_MIN_PIXELS, 16: overlap pixels within one frame needed to count as a player hit. Legal range 1..255.
- INVULN_FRAMES, 60: frames after a player hit during which player contact is ignored. Legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse at the start of each frame
- start  in  1  one-cycle pulse that begins a new game
- bubbleDrawingRequest  in  1  OR of all bubble drawing requests for the current pixel
- arrowDrawingRequest  in  1  arrow is drawing the current pixel
- playerDrawingRequest  in  1  player is drawing the current pixel
- arrowHit  out  1  combinational hit strobe to the bubble array
- arrowRetract  out  1  registered one-cycle pulse to the arrow block
- playerHit  out  1  registered one-cycle pulse
- lives  out  4  remaining lives
- invulnerable  out  1  invulnerability window is active
- gameOver  out  1  sticky game-over flag

Behaviour:
- Reset (synchronous, active-high):
  - Arrow FSM goes to ARMED; cooldown counter = 0.
  - Overlap counter = 0; invulnerability counter = 0.
  - lives = START_LIVES; gameOver = 0.
  - arrowRetract, playerHit and invulnerable read 0 from the first cycle after reset.
  - While reset is high, arrowHit = 0.
- Arrow FSM states: ARMED, COOLDOWN, GAME_OVER.
  - arrowHit = (state==ARMED) & arrowDrawingRequest & bubbleDrawingRequest & ~reset.
  - arrowHit is combinational (zero latency) so the bubble array sees it on the same pixel cycle as its own drawing request.
  - ARMED -> COOLDOWN on the cycle arrowHit = 1. The cooldown counter loads COOLDOWN_FRAMES, and arrowRetract pulses high for exactly the next cycle.
  - This means at most one arrowHit cycle per hit. Later overlapping pixels in the same frame are ignored.
  - In COOLDOWN, each startOfFrame decrements the counter. On the startOfFrame where the counter is 1, it goes to 0 and the state returns to ARMED on the next cycle.
  - Any state -> GAME_OVER when gameOver sets. In GAME_OVER, arrowHit = 0 and arrowRetract = 0.
- Player overlap detection:
  - An 8-bit overlap counter increments, saturating at 255, on each cycle with playerDrawingRequest & bubbleDrawingRequest.
  - On startOfFrame, the counter value from the frame just ended is evaluated, then the counter is reloaded.
  - Reload value is 1 if an overlap pixel coincides with the startOfFrame cycle, else 0; that pixel belongs to the new frame.
  - A player hit is registered when count >= PLAYER_MIN_PIXELS and invulnerable = 0 and gameOver = 0.
- On a registered player hit:
  - playerHit = 1 for the one cycle after the startOfFrame.
  - lives decrements by 1, floored at 0.
  - The invulnerability counter loads INVULN_FRAMES.
  - If lives was 1, lives becomes 0 and gameOver sets on that same edge.
- invulnerable = (invulnerability counter != 0). The counter decrements by 1 on each startOfFrame while nonzero. The startOfFrame that loads it does not also decrement it.
- gameOver stays set until reset or start.
- start (level-sampled, one cycle):
  - lives = START_LIVES, gameOver = 0, state = ARMED.
  - All counters are cleared and pending pulses are cancelled.
  - If start and reset are both high, reset wins; the end result is identical.
- Simultaneous startOfFrame and arrowHit on one cycle: the hit is taken and the cooldown loads COOLDOWN_FRAMES; this startOfFrame does not decrement it.
- Simultaneous arrow hit and player hit: both are processed independently in the same cycle.
- Reset during COOLDOWN or invulnerability: all counters return to 0 and no pulse is emitted afterwards.

Test Plan:
- Hit and retract: ARMED; drive arrow=bubble=1 for 5 consecutive cycles.
  - arrowHit = 1 on the first cycle only.
  - arrowRetract = 1 on the second cycle only.
  - State is COOLDOWN.
- Cooldown timing: after a hit with COOLDOWN_FRAMES=4, apply overlap every frame.
  - arrowHit stays 0 across the next 4 startOfFrame pulses.
  - arrowHit fires again on the first overlap after the 4th startOfFrame.
- Player threshold: 15 overlap pixels in frame N, then startOfFrame.
  - No playerHit; lives stays 3.
- Player threshold met: 16 overlap pixels in frame N+1, then startOfFrame.
  - playerHit pulses one cycle later; lives = 2; invulnerable = 1.
- Invulnerability: 100 overlap pixels per frame for the next 60 frames.
  - lives stays 2.
  - invulnerable drops after the 60th startOfFrame following the hit.
  - The next qualifying frame decrements lives to 1.
- Game over and restart:
  - Drive lives from 1 to 0 via a qualifying frame: gameOver = 1.
  - Then apply arrow/bubble overlap: arrowHit stays 0.
  - Then pulse start: lives = 3, gameOver = 0, arrowHit is live again.
  - Assert reset mid-COOLDOWN: all outputs return to their reset values on the next cycle.
